// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and stream-format constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam int MEM_DEPTH_DEFAULT = 1024;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 1;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - packs an MSB-first byte stream into 32-bit instruction words
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    // Only the first three bytes need storage; the fourth is taken straight from the input.
    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    assign word       = {shift_q, byte_data};
    assign word_ready = byte_valid && (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[15:0], byte_data};
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a checksummed byte-stream image into instruction memory and gates the core
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    loader_state_t state_q, next_state;

    logic [7:0]    n_lo_q;
    logic [15:0]   n_q;
    logic [ADDR_W:0] word_idx_q;
    logic [7:0]    xor_q;

    logic        accept;
    logic        rearm;
    logic [15:0] len_full;
    logic        oversize;
    logic        last_word;
    logic        csum_ok;
    logic [31:0] packed_word;
    logic        word_ready;

    assign accept    = in_valid && in_ready;
    assign rearm     = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign len_full  = {in_data, n_lo_q};
    assign oversize  = {1'b0, len_full} > 17'(MEM_DEPTH);
    assign last_word = (16'(word_idx_q) + 16'd1) == n_q;
    assign csum_ok   = (in_data == xor_q);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (rearm),
        .byte_valid (accept && state_q == DATA),
        .byte_data  (in_data),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) next_state = LEN_LO;
            LEN_LO:          if (accept) next_state = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (oversize)            next_state = ERR;
                    else if (len_full == '0) next_state = CSUM;
                    else                     next_state = DATA;
                end
            end
            DATA:            if (word_ready && last_word) next_state = CSUM;
            CSUM:            if (accept) next_state = csum_ok ? DONE : ERR;
            default:         next_state = IDLE;
        endcase
    end

    // Handshake and status outputs are registered from next_state so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready   <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            n_lo_q     <= '0;
            n_q        <= '0;
            word_idx_q <= '0;
            xor_q      <= '0;
        end else begin
            state_q  <= next_state;
            in_ready <= (next_state == LEN_LO) || (next_state == LEN_HI) ||
                        (next_state == DATA)   || (next_state == CSUM);
            cpu_hold <= (next_state != DONE);
            done     <= (state_q == CSUM) && (next_state == DONE);
            err      <= (next_state == ERR);
            imem_we  <= word_ready;

            if (word_ready) begin
                imem_addr  <= word_idx_q[ADDR_W-1:0];
                imem_wdata <= packed_word;
            end

            if (accept && state_q == LEN_LO) n_lo_q <= in_data;
            if (accept && state_q == LEN_HI) n_q    <= len_full;

            if (rearm)           word_idx_q <= '0;
            else if (word_ready) word_idx_q <= word_idx_q + 1'b1;

            if (rearm)                          xor_q <= '0;
            else if (accept && state_q != CSUM) xor_q <= xor_q ^ in_data;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       imem_we;
    logic [9:0] imem_addr;
    logic [31:0] imem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Event log, sampled on the falling edge.
    int cyc = 0;
    int acc_cnt = 0;
    int acc_stamp[16];
    int we_cnt = 0;
    logic [31:0] wr_addr[8];
    logic [31:0] wr_data[8];
    int wr_stamp[8];
    int done_cnt = 0;
    int done_stamp = 0;
    int ready_drop = 0;
    logic chk_ready = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_ready && acc_cnt >= 2 && acc_cnt < 11 && !in_ready) ready_drop++;
        if (in_valid && in_ready) begin
            if (acc_cnt < 16) acc_stamp[acc_cnt] = cyc + 1;
            acc_cnt++;
        end
        if (imem_we) begin
            if (we_cnt < 8) begin
                wr_addr[we_cnt]  = 32'(imem_addr);
                wr_data[we_cnt]  = imem_wdata;
                wr_stamp[we_cnt] = cyc;
            end
            we_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_stamp = cyc;
        end
    end

    task automatic clear_log();
        acc_cnt    = 0;
        we_cnt     = 0;
        done_cnt   = 0;
        ready_drop = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    logic [7:0] img[$];

    task automatic send_img(input int max_gap);
        foreach (img[i]) send_byte(img[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    endtask

    task automatic load_good_img();
        img = '{8'h02, 8'h00, 8'h09, 8'h0C, 8'h80, 8'h00, 8'h0D, 8'h44, 8'h00, 8'h1B, 8'hD5};
    endtask

    task automatic good_load(input string tag, input int max_gap);
        clear_log();
        pulse_start();
        check({tag, "_rearm_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_rearm_hold"}, 32'(cpu_hold), 32'd1);
        load_good_img();
        send_img(max_gap);
        repeat (3) @(negedge clk);
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'd2);
        check({tag, "_addr0"}, wr_addr[0], 32'd0);
        check({tag, "_data0"}, wr_data[0], 32'h090C8000);
        check({tag, "_addr1"}, wr_addr[1], 32'd1);
        check({tag, "_data1"}, wr_data[1], 32'h0D44001B);
        check({tag, "_w0_lat"}, 32'(wr_stamp[0]), 32'(acc_stamp[5]));
        check({tag, "_w1_lat"}, 32'(wr_stamp[1]), 32'(acc_stamp[9]));
        if (max_gap == 0) check({tag, "_w_spacing"}, 32'(wr_stamp[1] - wr_stamp[0]), 32'd4);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_lat"}, 32'(done_stamp), 32'(acc_stamp[10]));
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_ready_idle"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd0);

        good_load("b2b", 0);

        chk_ready = 1'b1;
        good_load("gaps", 2);
        chk_ready = 1'b0;
        check("gaps_ready_drop", 32'(ready_drop), 32'd0);

        // Bad checksum
        clear_log();
        pulse_start();
        load_good_img();
        img[10] = 8'hD4;
        send_img(0);
        repeat (3) @(negedge clk);
        check("badcs_we_cnt", 32'(we_cnt), 32'd2);
        check("badcs_done", 32'(done_cnt), 32'd0);
        check("badcs_err", 32'(err), 32'd1);
        check("badcs_hold", 32'(cpu_hold), 32'd1);
        check("badcs_ready", 32'(in_ready), 32'd0);
        pulse_start();
        check("badcs_clr_err", 32'(err), 32'd0);
        check("badcs_clr_ready", 32'(in_ready), 32'd1);

        // Oversize length 1025 (already armed)
        clear_log();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        @(negedge clk);
        check("big_err", 32'(err), 32'd1);
        check("big_ready", 32'(in_ready), 32'd0);
        repeat (4) @(negedge clk);
        check("big_we_cnt", 32'(we_cnt), 32'd0);

        // Exactly MEM_DEPTH is accepted into DATA
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        @(negedge clk);
        check("full_err", 32'(err), 32'd0);
        check("full_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Empty image, wrong then right checksum
        clear_log();
        pulse_start();
        img = '{8'h00, 8'h00, 8'h02};
        send_img(0);
        repeat (2) @(negedge clk);
        check("empty_bad_err", 32'(err), 32'd1);
        check("empty_bad_done", 32'(done_cnt), 32'd0);
        clear_log();
        pulse_start();
        img = '{8'h00, 8'h00, 8'h00};
        send_img(0);
        repeat (2) @(negedge clk);
        check("empty_ok_done", 32'(done_cnt), 32'd1);
        check("empty_ok_err", 32'(err), 32'd0);
        check("empty_ok_hold", 32'(cpu_hold), 32'd0);
        check("empty_ok_we", 32'(we_cnt), 32'd0);

        // Reset mid-load after 6 data bytes
        clear_log();
        pulse_start();
        load_good_img();
        for (int i = 0; i < 8; i++) send_byte(img[i], 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        repeat (4) @(negedge clk);
        check("mid_rst_we_cnt", 32'(we_cnt), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        good_load("after_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writes program images into the processor's instruction memory. A byte stream arrives over a valid/ready handshake; the block packs it into 32-bit instruction words, writes them to consecutive word addresses, and checks an XOR checksum at the end. While loading, it holds the multi-cycle core off, and releases it once a correct image is in place.

## Interface
Parameters:
- MEM_DEPTH, 1024: instruction-memory depth in 32-bit words.
- ADDR_W, 10: word-address width, equal to clog2(MEM_DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request to begin a new load.
- in_valid  in  1  in_data carries a valid byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address being written.
- imem_wdata  out  32  instruction word being written.
- cpu_hold  out  1  keeps the processor in reset or stalled.
- done  out  1  one-cycle pulse when an image loads with a good checksum.
- err  out  1  sticky flag for a bad length or a checksum mismatch.

## Operation
- A byte is accepted only when in_valid and in_ready are both high. Bytes are never dropped or duplicated.
- Image format, in stream order:
  - Word count N as 16 bits, little-endian (low byte first).
  - N words, each sent as 4 bytes, most-significant byte first.
  - One checksum byte, equal to the XOR of every preceding byte, including the length bytes.
- State machine (state type held in the shared package):
  - IDLE: in_ready=0. A start pulse clears err, the word index, the byte index and the running XOR, then moves to LEN_LO.
  - LEN_LO: in_ready=1. The accepted byte becomes the low byte of N. Next state is LEN_HI.
  - LEN_HI: in_ready=1. The accepted byte becomes the high byte of N.
    - If N > MEM_DEPTH, go to ERR.
    - If N == 0, go to CSUM.
    - Otherwise go to DATA.
  - DATA: in_ready=1. Each byte shifts into a 32-bit packer. When the 4th byte of a word is accepted, a write is issued and the word index increments. After word N-1, go to CSUM.
  - CSUM: in_ready=1. The accepted byte is compared with the running XOR.
    - On a match, go to DONE and pulse done.
    - On a mismatch, go to ERR.
  - DONE: in_ready=0, cpu_hold=0. A start pulse re-arms to LEN_LO.
  - ERR: in_ready=0, err=1, cpu_hold=1. A start pulse re-arms to LEN_LO.
- start is ignored in LEN_LO, LEN_HI, DATA and CSUM.
- Words already written before an error are not rolled back. err marks the whole image invalid.
- cpu_hold=1 in every state except DONE, and also during reset.

## Timing
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, done=0, err=0, state IDLE.
- Reset asserted mid-load returns the block to IDLE immediately. No further writes occur, and imem_we drops asynchronously.
- Throughput is one byte per cycle. When in_valid is held high, words are written every 4 cycles. There is no bubble between words.
- Write latency: imem_we, imem_addr and imem_wdata are registered. They are valid in the cycle after the 4th byte of a word is accepted, for exactly one cycle.
- Word addresses: word k is written to imem_addr=k, for k = 0 to N-1. N == MEM_DEPTH fills the memory exactly. No address wraps.
- in_ready is a registered function of state only. in_valid low stalls the load indefinitely; there is no timeout.
- done rises the cycle after the checksum byte is accepted, and cpu_hold falls in that same cycle.
- err rises the cycle after the offending byte is accepted: the LEN_HI byte or the checksum byte.
- A start pulse in DONE or ERR: in_ready=1 and cpu_hold=1 from the next cycle.

## Structure
- Shared package holds:
  - the loader state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR);
  - the MEM_DEPTH default;
  - the byte-stream format constants: 2 length bytes, 4 bytes per word, 1 checksum byte.
- One sub-module: byte_packer. It shifts bytes MSB-first into a 32-bit word, keeps the 2-bit byte index, and raises word_ready on the 4th byte.
- The FSM, word counter, XOR accumulator and write-port registers live in imem_loader.

## Test plan
- Two-word load: start, then bytes 02 00 09 0C 80 00 0D 44 00 1B D5 sent back-to-back.
  - Expect writes 090C8000 at address 0 and 0D44001B at address 1, each 1 cycle after its 4th byte, 4 cycles apart.
  - done pulses once, cpu_hold drops, err=0.
- Same stream with random in_valid gaps: identical writes and done. in_ready stays high throughout DATA.
- Bad checksum (last byte D4): both words are written, no done, err=1, cpu_hold=1. A later start clears err.
- Oversize length bytes 01 04 (N=1025): ERR right after the second byte, no imem_we pulses.
- Empty image, bytes 00 00 02 (checksum of 00 and 00 with a wrong value): ERR. Bytes 00 00 00: done with no writes.
- rst_n pulled low after 6 data bytes: outputs return to reset values at once, with no write for the partial word. A fresh start then loads correctly.
